// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer and the multiplier control FSM:
// operation modes, FSM states and small helpers on the mode field.
package shift_pkg;

  localparam logic [2:0] MODE_LOAD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ASR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Modes 6 and 7 are reserved and complete without touching the data
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-bit step: produces the next word and the bit pushed out
// for the selected shift or rotate mode.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WL = 8
) (
  input  logic [2:0]    mode,
  input  logic [WL-1:0] cur,
  input  logic          ser_in,
  output logic [WL-1:0] nxt,
  output logic          ejected
);

  always_comb begin
    nxt     = cur;
    ejected = 1'b0;
    case (mode)
      MODE_SHL: begin
        nxt     = {cur[WL-2:0], ser_in};
        ejected = cur[WL-1];
      end
      MODE_SHR: begin
        nxt     = {ser_in, cur[WL-1:1]};
        ejected = cur[0];
      end
      MODE_ASR: begin
        nxt     = {cur[WL-1], cur[WL-1:1]};
        ejected = cur[0];
      end
      MODE_ROL: begin
        nxt     = {cur[WL-2:0], cur[WL-1]};
        ejected = cur[WL-1];
      end
      MODE_ROR: begin
        nxt     = {cur[0], cur[WL-1:1]};
        ejected = cur[0];
      end
      default: begin
        nxt     = cur;
        ejected = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-mode shift register with a shift-count sequencer: accepts one command per
// start strobe, steps one bit per cycle while busy, and pulses done on completion.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WL = 8,
  parameter int CW = $clog2(WL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] amount,
  input  logic [WL-1:0] load_data,
  input  logic          ser_in,
  output logic [WL-1:0] out,
  output logic          carry,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [2:0]    mode_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] amt_clamped;
  logic [WL-1:0] step_word;
  logic          step_bit;

  assign amt_clamped = (amount > CW'(WL)) ? CW'(WL) : amount;

  shift_step_unit #(.WL(WL)) u_step (
    .mode    (mode_q),
    .cur     (out),
    .ser_in  (ser_in),
    .nxt     (step_word),
    .ejected (step_bit)
  );

  // DONE accepts a new command exactly like IDLE so commands can run back to back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_LOAD;
      cnt    <= '0;
      out    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (mode == MODE_LOAD) begin
              out   <= load_data;
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (!is_shift_mode(mode) || (amount == '0)) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              mode_q <= mode;
              cnt    <= amt_clamped;
              busy   <= 1'b1;
              state  <= ST_SHIFT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          out   <= step_word;
          carry <= step_bit;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Parametrised multi-mode shift register with a built-in shift-count sequencer. It is the next generation of the team's single-direction left shift register. It adds parallel load, logical/arithmetic/rotate shifts in both directions, a multi-cycle shift-by-N operation with start/busy/done handshake, and a carry-out of the last bit shifted. It sits in the multiplier/divider datapath, driven by the control FSM that issues one shift command per partial-product step.

## Interface
- WL, default 8: data word length in bits; WL >= 2.
- CW, default $clog2(WL+1): width of the shift-amount port. Derived from WL; do not override.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. This is fixed: one clock, with reset asynchronous and active-low.
- start  in  1  command strobe; accepted only while busy = 0.
- mode  in  3  operation select, captured on accept:
  - 0 LOAD
  - 1 SHL (fill ser_in)
  - 2 SHR (fill ser_in)
  - 3 ASR (fill MSB)
  - 4 ROL
  - 5 ROR
  - 6-7 reserved
- amount  in  CW  number of 1-bit shift steps; captured on accept.
- load_data  in  WL  parallel load value; used by LOAD only.
- ser_in  in  1  serial fill bit for SHL/SHR; sampled live on every shift step.
- out  out  WL  register contents.
- carry  out  1  last bit shifted or rotated out; unchanged by LOAD.
- busy  out  1  high while shift steps are in progress.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - On start with LOAD: out <= load_data. Go to DONE.
  - On start with amount = 0 or a reserved mode: no data change. Go to DONE.
  - On start with any other mode: capture mode; cnt <= min(amount, WL); go to SHIFT.
- SHIFT: each cycle, apply one 1-bit step per the captured mode, set carry to the ejected bit, and decrement cnt. When cnt = 1, take the final step and go to DONE.
- DONE: done = 1 for exactly this cycle. start is accepted here exactly as in IDLE, so back-to-back commands are allowed. With no start, go to IDLE.
- Step definitions:
  - SHL: out <= {out[WL-2:0], ser_in}; carry <= out[WL-1].
  - SHR: out <= {ser_in, out[WL-1:1]}; carry <= out[0].
  - ASR: as SHR, but fill with out[WL-1].
  - ROL and ROR: rotate; carry is the bit that wrapped.
- mode, amount and load_data are ignored while busy. start while busy is dropped; it is not queued.
- amount > WL is clamped to WL; no error is flagged.
- Reset mid-operation: asynchronous clear. The command is abandoned with no done pulse.

## Timing
- Reset values: out = 0, carry = 0, busy = 0, done = 0, state = IDLE, cnt = 0.
- Shift command with k = min(amount, WL) >= 1, accepted at edge E0:
  - busy is high from after E0 through after E(k-1).
  - out holds the i-th step result after edge Ei.
  - done is high for the one cycle after Ek, with busy low.
- LOAD, amount = 0 and reserved modes: out updates (LOAD) and done is high in the single cycle after the accept edge; busy is never asserted.
- Throughput: one command per k+1 cycles. With start held continuously, a new command is accepted in every DONE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package shift_pkg holds the mode encodings (MODE_LOAD through MODE_ROR) and the FSM state encoding. It is shared with the multiplier control FSM.
- Sub-module shift_step_unit: combinational one-bit step. It takes the mode, current word and ser_in, and returns the next word and the ejected bit.
- The top level holds the FSM, cnt, and the out/carry registers.

## Test plan (WL = 8)
- LOAD 0xA5: out = 0xA5 and done = 1 the cycle after accept; busy never high; carry unchanged.
- From 0x81, SHL amount 3, ser_in = 1: out steps 0x03, 0x07, 0x0F; carry final = 0; busy for 3 cycles; done on cycle 4.
- From 0x90, ASR amount 2: out = 0xC8 then 0xE4; carry = 0.
- From 0x3C, ROR amount 9 (clamped to 8): busy for 8 cycles; final out = 0x3C; carry = 0. A start pulse during busy is ignored and out is unaffected.
- amount = 0, then mode 6: each gives done in the next cycle with out unchanged. Back-to-back start in the DONE cycle is accepted.
- rst low during step 2 of an SHL amount-5 command: out = 0 and busy = 0 immediately, with no clock edge required; done never pulses; after release the FSM is IDLE.
